// File: rtl/program_counter_reg_if.sv
// ----------------------------------------------------------------------------
// program_counter_reg_if
//   Groups the fetch-address signals that pass between the next-PC logic and
//   the program counter register.
//   Signals:
//     stall      - hold the current PC (next-PC logic -> PC register)
//     addr_in    - next PC value      (next-PC logic -> PC register)
//     addr_out   - current PC         (PC register -> fetch / next-PC logic)
//     misaligned - alignment-fault flag, present only when PC_ALIGN_CHECK_EN
//                  is defined        (PC register -> trap logic)
//   Modports:
//     master - next-PC logic side (drives stall/addr_in)
//     slave  - PC register side   (drives addr_out/misaligned)
//   Build macro: PC_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
interface program_counter_reg_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] addr_out;
`ifdef PC_ALIGN_CHECK_EN
  logic             misaligned;
`endif

  modport master (
    output stall,
    output addr_in,
`ifdef PC_ALIGN_CHECK_EN
    input  misaligned,
`endif
    input  addr_out
  );

  modport slave (
    input  stall,
    input  addr_in,
`ifdef PC_ALIGN_CHECK_EN
    output misaligned,
`endif
    output addr_out
  );
endinterface

// File: rtl/program_counter_reg.sv
// ----------------------------------------------------------------------------
// program_counter_reg
//   Instruction-fetch program counter. Captures the next PC on every rising
//   clock edge unless stalled; synchronous active-high reset to RESET_ADDR.
//   No increment/branch logic here -- that lives upstream.
//   Parameters:
//     WIDTH      - address width in bits (must be >= 3 with the check enabled)
//     RESET_ADDR - value loaded on reset
//   Ports:
//     clk  - system clock, rising edge active
//     rst  - synchronous active-high reset (priority over stall)
//     bus  - program_counter_reg_if.slave: stall, addr_in in;
//            addr_out (registered), misaligned (registered, optional) out
//   Build macro: PC_ALIGN_CHECK_EN
//     defined   - loads addr_in with bits [1:0] cleared and flags a nonzero
//                 low pair on misaligned
//     undefined - loads addr_in unmodified; no misaligned signal
//   No power-on initializer: addr_out is X until the first reset or load.
// ----------------------------------------------------------------------------
module program_counter_reg #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic                clk,
  input logic                rst,
  program_counter_reg_if.slave bus
);

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] w_load_addr;

`ifdef PC_ALIGN_CHECK_EN
  logic r_mis;
  logic w_mis;

  // Force word alignment on the fetch address; report the dropped bits.
  assign w_load_addr = {bus.addr_in[WIDTH-1:2], 2'b00};
  assign w_mis       = |bus.addr_in[1:0];

  always_ff @(posedge clk) begin
    if (rst)             r_mis <= 1'b0;
    else if (!bus.stall) r_mis <= w_mis;
  end

  assign bus.misaligned = r_mis;
`else
  assign w_load_addr = bus.addr_in;
`endif

  always_ff @(posedge clk) begin
    if (rst)             r_addr <= RESET_ADDR;
    else if (!bus.stall) r_addr <= w_load_addr;
  end

  // Pure register output: no combinational path from any input.
  assign bus.addr_out = r_addr;

endmodule

// File: tb/tb_program_counter_reg.sv
// ----------------------------------------------------------------------------
// tb_program_counter_reg
//   Self-checking bench for program_counter_reg: a directed vector table,
//   hand-written between-edge sequences, then randomized traffic against a
//   behavioural model. Works with or without PC_ALIGN_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_program_counter_reg;
  localparam int          W     = 32;
  localparam logic [31:0] RADDR = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  program_counter_reg_if #(.WIDTH(W)) bus ();

  program_counter_reg #(.WIDTH(W), .RESET_ADDR(RADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [31:0] a;
    logic [31:0] e_raw;  // expected addr_out, check disabled
    logic [31:0] e_al;   // expected addr_out, check enabled
    logic        e_mis;  // expected misaligned, check enabled
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic get_mis();
`ifdef PC_ALIGN_CHECK_EN
    return bus.misaligned;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_state(input string name, input logic [31:0] e_addr, input logic e_mis);
    chk({name, ".addr"}, bus.addr_out, e_addr);
    if (ALIGN) chk({name, ".mis"}, {31'b0, get_mis()}, {31'b0, e_mis});
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] a);
    rst = r; bus.stall = s; bus.addr_in = a;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] a,
                              input logic [31:0] er, input logic [31:0] ea, input logic em);
    vec_t v;
    v.rst = r; v.stall = s; v.a = a; v.e_raw = er; v.e_al = ea; v.e_mis = em;
    return v;
  endfunction

  logic [31:0] m_addr;
  logic        m_mis;
  logic        r_r, r_s;
  logic [31:0] r_a;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; bus.stall = 1'b0; bus.addr_in = '0;

    tbl[0]  = mk(1, 0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0);
    tbl[1]  = mk(0, 0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 0);
    tbl[2]  = mk(0, 0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1);
    tbl[3]  = mk(0, 0, 32'h0000_000A, 32'h0000_000A, 32'h0000_0008, 1);
    tbl[4]  = mk(0, 1, 32'h0000_0100, 32'h0000_000A, 32'h0000_0008, 1);
    tbl[5]  = mk(0, 1, 32'h0000_0100, 32'h0000_000A, 32'h0000_0008, 1);
    tbl[6]  = mk(0, 1, 32'h0000_0100, 32'h0000_000A, 32'h0000_0008, 1);
    tbl[7]  = mk(0, 0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 0);
    tbl[8]  = mk(1, 1, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000, 0);
    tbl[9]  = mk(0, 0, 32'h0000_000C, 32'h0000_000C, 32'h0000_000C, 0);
    tbl[10] = mk(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1);
    tbl[11] = mk(0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    tbl[12] = mk(0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].a);
      chk_state($sformatf("vec%0d", i), ALIGN ? tbl[i].e_al : tbl[i].e_raw, ALIGN ? tbl[i].e_mis : 1'b0);
    end

    // addr_in change between edges (across a falling edge) must be ignored
    step(0, 0, 32'h0000_0001);
    bus.addr_in = 32'h0000_0018;
    #6;
    chk_state("mid_change", ALIGN ? 32'h0 : 32'h1, ALIGN);

    // rst raised between edges takes effect only at the next rising edge
    rst = 1'b1;
    #2;
    chk_state("mid_rst_hold", ALIGN ? 32'h0 : 32'h1, ALIGN);
    step(1, 0, 32'h0000_0018);
    chk_state("mid_rst_edge", RADDR, 1'b0);

    // stall then release loads the pending value
    step(0, 0, 32'h0000_0104);
    step(0, 1, 32'h0000_0203);
    chk_state("stall_hold", 32'h0000_0104, 1'b0);
    step(0, 0, 32'h0000_0203);
    chk_state("stall_rel", ALIGN ? 32'h0000_0200 : 32'h0000_0203, ALIGN);

    // randomized traffic vs behavioural model
    step(1, 0, $urandom);
    m_addr = RADDR; m_mis = 1'b0;
    chk_state("rand_rst", m_addr, m_mis);
    for (int i = 0; i < 300; i++) begin
      r_r = ($urandom_range(15) == 0);
      r_s = ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0:       r_a = 32'hFFFF_FFFF;
        1:       r_a = 32'h0000_0000;
        2:       r_a = m_addr + 32'd4;
        default: r_a = $urandom;
      endcase
      step(r_r, r_s, r_a);
      if (r_r) begin
        m_addr = RADDR; m_mis = 1'b0;
      end else if (!r_s) begin
        m_addr = ALIGN ? (r_a / 4) * 4 : r_a;
        m_mis  = ALIGN && (r_a % 4 != 0);
      end
      chk_state($sformatf("rand%0d", i), m_addr, m_mis);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_counter_reg.md
# program_counter_reg

Program counter register for the processor's instruction-fetch stage. It captures the next-instruction address presented by the next-PC logic on every rising clock edge and drives the current fetch address to instruction memory. It includes a synchronous active-high reset to a fixed boot address, a stall hold, and an optional word-alignment check.

## Interface
Parameters:
- `WIDTH`, default 32: address width in bits.
- `RESET_ADDR`, default 32'h0000_0000: value loaded into `addr_out` on reset.

Ports:
- `clk`, input, 1: system clock. All state updates occur on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `stall`, input, 1: hold the current PC. Integrators tie it to 0 when unused.
- `addr_in`, input, WIDTH: next PC value from the next-PC logic.
- `addr_out`, output, WIDTH: current PC. This is a register output.
- `misaligned`, output, 1: registered alignment-fault flag. It exists only when `PC_ALIGN_CHECK_EN` is defined.

## Operation
- At each rising edge of `clk`, the first matching case applies:
  - `rst`=1: `addr_out` loads `RESET_ADDR`, and `misaligned` loads 0.
  - `stall`=1: `addr_out` and `misaligned` hold their values.
  - Otherwise: `addr_out` loads `addr_in`. With the check enabled, the value loaded is `addr_in` with bits [1:0] cleared.
- The block has no internal adder. Increment and branch selection happen upstream.
- `addr_out` is never combinationally dependent on any input.
- `rst` has priority over `stall`.
- `addr_in` is treated as an opaque WIDTH-bit value. There is no wrap-around or saturation logic; 32'hFFFF_FFFF loads as-is.

## Timing
- Latency is one cycle. The `addr_in` value sampled at edge N appears on `addr_out` immediately after edge N.
- Changes on `addr_in` between rising edges have no effect. Falling edges are ignored.
- Reset is synchronous. Asserting `rst` between edges does not change `addr_out` until the next rising edge.
- Reset asserted mid-stream discards the `addr_in` present at that edge.
- Before the first rising edge with `rst`=1 or a load, `addr_out` is undefined (X in simulation). There is no power-on initializer.
- `misaligned` follows the same edge timing and priority as `addr_out`.

## Configuration
- `PC_ALIGN_CHECK_EN`, when defined:
  - The `misaligned` port exists.
  - On a load, `misaligned` registers (`addr_in[1:0] != 0`).
  - `addr_out` loads `{addr_in[WIDTH-1:2], 2'b00}`.
- When undefined:
  - The `misaligned` port is absent.
  - `addr_out` loads `addr_in` unmodified, including the low bits.

## Test plan
- Reset: `rst`=1 for one edge with `addr_in`=32'h0000_0040 -> `addr_out`=`RESET_ADDR` (32'h0). Then `rst`=0 -> the next edge loads 32'h0000_0040.
- Basic load, macro off: rising edge with `addr_in`=32'h0000_0001 -> `addr_out`=32'h0000_0001. `addr_in` changes to 32'h0000_0018 with no rising edge -> `addr_out` stays 32'h0000_0001. Next rising edge with `addr_in`=32'h0000_000A -> `addr_out`=32'h0000_000A.
- Stall: `stall`=1 with `addr_in`=32'h0000_0100 over 3 edges -> `addr_out` unchanged. Release `stall` -> 32'h0000_0100 loads on the next edge.
- Priority: `rst`=1 and `stall`=1 together -> `addr_out`=`RESET_ADDR`.
- Alignment, macro on: `addr_in`=32'h0000_000A -> `addr_out`=32'h0000_0008 and `misaligned`=1. Then `addr_in`=32'h0000_000C -> `addr_out`=32'h0000_000C and `misaligned`=0.
- Full width: `addr_in`=32'hFFFF_FFFC then 32'h0000_0000 -> values load exactly, with no wrap side effects.
